ttt_board: RTL and testbench
============================

# ttt_board

Board-state keeper for the tic-tac-toe game, directly upstream of the `sm_ttt` game FSM. It holds the 3x3 grid and a player cursor moved by debounced button pulses. It accepts mark placements from the human or computer side and produces the `legal_move`, `winner_found` and `full` flags that `sm_ttt` consumes. It runs on the same divided system clock as `sm_ttt`.

## Interface
Parameters:
- `CURSOR_INIT`, default 4: cursor index after reset/clear (centre cell).

Ports (all single-bit inputs are level-sampled on the rising edge of `Clk`):
- `Clk`  in  1  system clock; same clock as `sm_ttt`.
- `reset`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous new-game clear.
- `up`, `down`, `left`, `right`  in  1 each  cursor move pulses, one cycle each.
- `cursor_load`  in  1  load the cursor from `cursor_idx` (computer move).
- `cursor_idx`  in  4  target cell, 0..8.
- `place`  in  1  place a mark at the cursor.
- `player`  in  1  mark owner: 0 = X (human), 1 = O (computer).
- `cursor`  out  4  current cell index, computed as row*3 + col.
- `board`  out  18  cell i is `board[2i+1:2i]`.
- `legal_move`  out  1  one-cycle pulse: placement accepted.
- `illegal`  out  1  one-cycle pulse: placement rejected.
- `winner_found`  out  1  a line of three is complete.
- `winner`  out  2  cell code of the winning mark; EMPTY if there is no winner.
- `full`  out  1  all 9 cells are occupied.
- `move_count`  out  4  number of accepted placements, 0..9.

## Operation
Cell codes:
- EMPTY = 00, X = 01, O = 10. Code 11 never occurs.

Reset (`reset`=0) and `clr`:
- `board` = 0, `cursor` = `CURSOR_INIT`, `move_count` = 0.
- All flags and pulses = 0.

Per-edge priority:
- `clr` over `cursor_load` over `place` and moves.
- `clr` discards every other input in that cycle.

`cursor_load`:
- With `cursor_idx` <= 8: `cursor` takes `cursor_idx`.
- With `cursor_idx` > 8: ignored, and no pulse is generated.
- All move pulses in that cycle are ignored.

Moves:
- Only one direction is applied per cycle, with priority up > down > left > right.
- up: row-1. down: row+1. left: col-1. right: col+1.
- Edge behaviour is set by the Configuration section.

`place`:
- Accepted when the cell at the pre-move cursor is EMPTY, `winner_found` = 0 and `full` = 0.
- Accepted: the cell is written with X or O (from `player`), `move_count` increments, and `legal_move` pulses.
- Otherwise: the board is unchanged and `illegal` pulses.

Simultaneous `place` and move:
- The placement uses the old cursor.
- The move is still applied.

Win check:
- Covers 8 lines: 3 rows, 3 columns, 2 diagonals.
- A line wins when its three cells are equal and non-EMPTY.
- Only one winner is possible, because play stops at the first win.

## Timing
- All outputs are registered.
- Placement sampled at edge N: `board`, `move_count` and `legal_move`/`illegal` update after edge N.
- `winner_found`, `winner` and `full` are computed from the next-state board, so they are valid in the same cycle as the updated `board`.
- `sm_ttt` sees the flags one edge after the move, with no extra latency.
- Pulses last exactly one cycle. A `place` held high for k cycles gives one `legal_move` followed by k-1 `illegal` pulses, since the cell is no longer EMPTY.
- `reset` asserted mid-game clears everything immediately, without waiting for a clock edge.
- Release of `reset` is expected to be synchronised externally.
- `move_count` saturates at 9.

## Configuration
The macro is `TTT_CURSOR_WRAP_EN`.
- Defined: moves wrap within the row/column. Example: left from col 0 goes to col 2, up from row 0 goes to row 2.
- Undefined: moves saturate at the grid edge, and the cursor stays put.

## Structure
- Package `ttt_pkg` holds:
  - the cell-code constants EMPTY/X/O;
  - the cell type (2 bits);
  - the 8-entry line table of cell-index triples;
  - `NUM_CELLS` = 9.
- Sub-module `ttt_win_check` is purely combinational:
  - input: the 18-bit board;
  - outputs: `winner_found`, `winner`, `full`.
- It is instantiated once on the next-state board.

## Test plan
- Reset, then 3 `right` pulses:
  - with `TTT_CURSOR_WRAP_EN`: `cursor` 4 -> 5 -> 3 -> 4;
  - without it: 4 -> 5 -> 5 -> 5.
- `place` with `player`=0 at cursor 4, then `place` again:
  - first: `board[9:8]`=01, `legal_move` pulses, `move_count`=1;
  - second: `illegal` pulses, `board` unchanged.
- Via `cursor_load`, place X at 0, O at 3, X at 1, O at 4, X at 2:
  - `winner_found`=1 and `winner`=01 in the cycle `board` shows cell 2 = X;
  - a further `place` at 8 -> `illegal`.
- Fill to a draw (X:0,1,5,6,8; O:2,3,4,7):
  - `full`=1, `winner_found`=0, `move_count`=9.
- `cursor_load` with `cursor_idx`=9 plus `up` in the same cycle:
  - cursor unchanged; `clr` together with `place` clears the board, with no pulse.
- Assert `reset` low mid-game, asynchronously between edges:
  - all outputs return to reset values at once, with `cursor`=4.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board keeper: cell codes, the
// winning-line table and cursor row/column helpers.
package ttt_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY = 2'b00;
    localparam cell_t X     = 2'b01;
    localparam cell_t O     = 2'b10;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    // Cell-index triples of every line of three. Entry order is irrelevant
    // to the win check, so the list is written in reading order.
    localparam logic [NUM_LINES-1:0][2:0][3:0] LINES = '{
        '{4'd0, 4'd1, 4'd2},   // top row
        '{4'd3, 4'd4, 4'd5},   // middle row
        '{4'd6, 4'd7, 4'd8},   // bottom row
        '{4'd0, 4'd3, 4'd6},   // left column
        '{4'd1, 4'd4, 4'd7},   // middle column
        '{4'd2, 4'd5, 4'd8},   // right column
        '{4'd0, 4'd4, 4'd8},   // main diagonal
        '{4'd2, 4'd4, 4'd6}    // anti diagonal
    };

    // Row of a cell index 0..8.
    function automatic logic [1:0] row_of(input logic [3:0] idx);
        if (idx < 4'd3)      return 2'd0;
        else if (idx < 4'd6) return 2'd1;
        else                 return 2'd2;
    endfunction

    // Column of a cell index 0..8.
    function automatic logic [1:0] col_of(input logic [3:0] idx);
        logic [3:0] base;
        case (row_of(idx))
            2'd0:    base = 4'd0;
            2'd1:    base = 4'd3;
            default: base = 4'd6;
        endcase
        return 2'(idx - base);
    endfunction

    // Cell index from row/column: row*3 + col.
    function automatic logic [3:0] to_idx(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] r4;
        r4 = {2'b00, row};
        return (r4 << 1) + r4 + {2'b00, col};
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Purely combinational board evaluator: detects a completed line of three
// and a fully occupied grid.
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    output logic        winner_found,
    output logic [1:0]  winner,
    output logic        full
);

    // Scan all eight lines and all nine cells.
    always_comb begin
        cell_t a, b, c;
        winner_found = 1'b0;
        winner       = EMPTY;
        full         = 1'b1;
        a            = EMPTY;
        b            = EMPTY;
        c            = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (board[2*i +: 2] == EMPTY) full = 1'b0;
        end
        for (int l = 0; l < NUM_LINES; l++) begin
            a = board[2*LINES[l][0] +: 2];
            b = board[2*LINES[l][1] +: 2];
            c = board[2*LINES[l][2] +: 2];
            // Play halts at the first win, so at most one line can match.
            if (a != EMPTY && a == b && b == c) begin
                winner_found = 1'b1;
                winner       = a;
            end
        end
    end

endmodule

// File: rtl/ttt_board.sv
// Tic-tac-toe board keeper: 3x3 grid, player cursor, placement validation
// and registered win/full flags for the downstream game FSM.
// Optional macro TTT_CURSOR_WRAP_EN: cursor moves wrap within the row/column
// instead of stopping at the grid edge.
module ttt_board
    import ttt_pkg::*;
#(
    parameter logic [3:0] CURSOR_INIT = 4'd4
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        cursor_load,
    input  logic [3:0]  cursor_idx,
    input  logic        place,
    input  logic        player,
    output logic [3:0]  cursor,
    output logic [17:0] board,
    output logic        legal_move,
    output logic        illegal,
    output logic        winner_found,
    output logic [1:0]  winner,
    output logic        full,
    output logic [3:0]  move_count
);

`ifdef TTT_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [3:0]  moved;
    logic [3:0]  cursor_nxt;
    logic [17:0] board_nxt;
    logic [3:0]  count_nxt;
    logic        legal_nxt;
    logic        illegal_nxt;
    logic        win_nxt;
    logic [1:0]  winner_nxt;
    logic        full_nxt;

    // Cursor after a single move, up > down > left > right.
    always_comb begin
        logic [1:0] row, col, row_n, col_n;
        row   = row_of(cursor);
        col   = col_of(cursor);
        row_n = row;
        col_n = col;
        if (up)
            row_n = (row == 2'd0) ? (WRAP ? 2'd2 : 2'd0) : row - 2'd1;
        else if (down)
            row_n = (row == 2'd2) ? (WRAP ? 2'd0 : 2'd2) : row + 2'd1;
        else if (left)
            col_n = (col == 2'd0) ? (WRAP ? 2'd2 : 2'd0) : col - 2'd1;
        else if (right)
            col_n = (col == 2'd2) ? (WRAP ? 2'd0 : 2'd2) : col + 2'd1;
        moved = to_idx(row_n, col_n);
    end

    // Next board/cursor/count and pulses; clr beats cursor_load beats place+moves.
    always_comb begin
        board_nxt   = board;
        cursor_nxt  = cursor;
        count_nxt   = move_count;
        legal_nxt   = 1'b0;
        illegal_nxt = 1'b0;
        if (clr) begin
            board_nxt  = '0;
            cursor_nxt = CURSOR_INIT;
            count_nxt  = 4'd0;
        end else if (cursor_load) begin
            // Out-of-range targets are dropped silently; moves and place are
            // discarded this cycle either way.
            if (cursor_idx <= 4'd8) cursor_nxt = cursor_idx;
        end else begin
            if (place) begin
                // Placement uses the cursor as it was before this cycle's move.
                if (board[2*cursor +: 2] == EMPTY && !winner_found && !full) begin
                    board_nxt[2*cursor +: 2] = player ? O : X;
                    if (move_count < 4'd9) count_nxt = move_count + 4'd1;
                    legal_nxt = 1'b1;
                end else begin
                    illegal_nxt = 1'b1;
                end
            end
            cursor_nxt = moved;
        end
    end

    // Flags evaluated on the next-state board so they line up with it.
    ttt_win_check u_win_check (
        .board        (board_nxt),
        .winner_found (win_nxt),
        .winner       (winner_nxt),
        .full         (full_nxt)
    );

    // Output registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            board        <= '0;
            cursor       <= CURSOR_INIT;
            move_count   <= 4'd0;
            legal_move   <= 1'b0;
            illegal      <= 1'b0;
            winner_found <= 1'b0;
            winner       <= EMPTY;
            full         <= 1'b0;
        end else begin
            board        <= board_nxt;
            cursor       <= cursor_nxt;
            move_count   <= count_nxt;
            legal_move   <= legal_nxt;
            illegal      <= illegal_nxt;
            winner_found <= win_nxt;
            winner       <= winner_nxt;
            full         <= full_nxt;
        end
    end

endmodule

// File: tb/tb_ttt_board.sv
// Directed self-checking bench for ttt_board.
module tb_ttt_board;
    import ttt_pkg::*;

`ifdef TTT_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic        cursor_load = 1'b0, place = 1'b0, player = 1'b0;
    logic [3:0]  cursor_idx = 4'd0;
    logic [3:0]  cursor;
    logic [17:0] board;
    logic        legal_move, illegal, winner_found, full;
    logic [1:0]  winner;
    logic [3:0]  move_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    ttt_board #(.CURSOR_INIT(4'd4)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .clr          (clr),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .cursor_load  (cursor_load),
        .cursor_idx   (cursor_idx),
        .place        (place),
        .player       (player),
        .cursor       (cursor),
        .board        (board),
        .legal_move   (legal_move),
        .illegal      (illegal),
        .winner_found (winner_found),
        .winner       (winner),
        .full         (full),
        .move_count   (move_count)
    );

    // One edge, then sample point 1ns later with all pulse inputs dropped.
    task automatic tick();
        @(posedge Clk);
        #1;
        clr = 0; up = 0; down = 0; left = 0; right = 0;
        cursor_load = 0; place = 0;
    endtask

    // Load the cursor, then place a mark there.
    task automatic put(input int idx, input logic p);
        cursor_load = 1; cursor_idx = 4'(idx);
        tick();
        place = 1; player = p;
        tick();
    endtask

    task automatic test_reset();
        reset = 0;
        tick(); tick();
        n_checks++;
        if ({board, cursor, move_count} !== {18'd0, 4'd4, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got board=%h cursor=%0d count=%0d, want 0/4/0", board, cursor, move_count);
        end
        n_checks++;
        if ({legal_move, illegal, winner_found, winner, full} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 000000", {legal_move, illegal, winner_found, winner, full});
        end
        reset = 1;
        tick();
    endtask

    task automatic test_cursor_move();
        logic [3:0] exp_seq [8];
        exp_seq = '{4'd5, WRAP ? 4'd3 : 4'd5, WRAP ? 4'd4 : 4'd5,
                    4'd1, WRAP ? 4'd7 : 4'd1, WRAP ? 4'd6 : 4'd0,
                    WRAP ? 4'd8 : 4'd0, WRAP ? 4'd2 : 4'd3};
        for (int i = 0; i < 8; i++) begin
            case (i)
                0, 1, 2: right = 1;
                3: begin up = 1; down = 1; clr = 0; end
                4: up = 1;
                5: begin left = 1; right = 1; end
                6: left = 1;
                default: down = 1;
            endcase
            if (i == 3) begin
                clr = 1; tick();   // back to centre before the priority steps
                up = 1; down = 1;
            end
            tick();
            n_checks++;
            if (cursor !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL cursor_step%0d: got %0d, want %0d", i, cursor, exp_seq[i]);
            end
        end
    endtask

    task automatic test_place();
        clr = 1; tick();
        place = 1; player = 0;
        tick();
        n_checks++;
        if ({board, legal_move, illegal, move_count} !== {18'h00100, 1'b1, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL place_first: got board=%h legal=%b illegal=%b count=%0d, want 00100/1/0/1", board, legal_move, illegal, move_count);
        end
        place = 1;
        tick();
        n_checks++;
        if ({board, legal_move, illegal, move_count} !== {18'h00100, 1'b0, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL place_again: got board=%h legal=%b illegal=%b count=%0d, want 00100/0/1/1", board, legal_move, illegal, move_count);
        end
        tick();
        n_checks++;
        if ({legal_move, illegal} !== 2'b00) begin
            n_fail++;
            $display("FAIL pulse_width: got %b, want 00", {legal_move, illegal});
        end
        // place with a simultaneous move: mark at old cursor, cursor still moves
        clr = 1; tick();
        place = 1; player = 1; right = 1;
        tick();
        n_checks++;
        if ({board, cursor, legal_move} !== {18'h00200, 4'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL place_with_move: got board=%h cursor=%0d legal=%b, want 00200/5/1", board, cursor, legal_move);
        end
    endtask

    task automatic test_win();
        clr = 1; tick();
        put(0, 0); put(3, 1); put(1, 0); put(4, 1);
        n_checks++;
        if (winner_found !== 1'b0) begin
            n_fail++;
            $display("FAIL win_early: got %b, want 0", winner_found);
        end
        put(2, 0);
        n_checks++;
        if ({board, winner_found, winner, legal_move, move_count} !== {18'h00295, 1'b1, 2'b01, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL win_row: got board=%h wf=%b winner=%b legal=%b count=%0d, want 00295/1/01/1/5", board, winner_found, winner, legal_move, move_count);
        end
        put(8, 1);
        n_checks++;
        if ({board, illegal, legal_move, move_count, winner_found} !== {18'h00295, 1'b1, 1'b0, 4'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL place_after_win: got board=%h illegal=%b legal=%b count=%0d wf=%b, want 00295/1/0/5/1", board, illegal, legal_move, move_count, winner_found);
        end
    endtask

    task automatic test_draw();
        int   cells [9];
        logic who   [9];
        cells = '{0, 2, 1, 3, 5, 4, 6, 7, 8};
        who   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        clr = 1; tick();
        for (int i = 0; i < 9; i++) put(cells[i], who[i]);
        n_checks++;
        if ({board, full, winner_found, winner, move_count} !== {18'h196A5, 1'b1, 1'b0, 2'b00, 4'd9}) begin
            n_fail++;
            $display("FAIL draw: got board=%h full=%b wf=%b winner=%b count=%0d, want 196a5/1/0/00/9", board, full, winner_found, winner, move_count);
        end
        place = 1; player = 0;
        tick();
        n_checks++;
        if ({illegal, legal_move, move_count, board} !== {1'b1, 1'b0, 4'd9, 18'h196A5}) begin
            n_fail++;
            $display("FAIL place_when_full: got illegal=%b legal=%b count=%0d board=%h, want 1/0/9/196a5", illegal, legal_move, move_count, board);
        end
    endtask

    task automatic test_load_invalid();
        clr = 1; tick();
        cursor_load = 1; cursor_idx = 4'd2;
        tick();
        cursor_load = 1; cursor_idx = 4'd9; up = 1;
        tick();
        n_checks++;
        if (cursor !== 4'd2) begin
            n_fail++;
            $display("FAIL load_out_of_range: got %0d, want 2", cursor);
        end
        cursor_load = 1; cursor_idx = 4'd7; right = 1; place = 1; player = 0;
        tick();
        n_checks++;
        if ({cursor, board, legal_move, illegal} !== {4'd7, 18'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL load_over_place: got cursor=%0d board=%h pulses=%b, want 7/0/00", cursor, board, {legal_move, illegal});
        end
        place = 1; player = 0;
        tick();
        n_checks++;
        if ({board, legal_move} !== {18'h04000, 1'b1}) begin
            n_fail++;
            $display("FAIL place_at_loaded: got board=%h legal=%b, want 04000/1", board, legal_move);
        end
        clr = 1; place = 1; player = 1;
        tick();
        n_checks++;
        if ({board, cursor, move_count, legal_move, illegal} !== {18'd0, 4'd4, 4'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL clr_with_place: got board=%h cursor=%0d count=%0d pulses=%b, want 0/4/0/00", board, cursor, move_count, {legal_move, illegal});
        end
    endtask

    task automatic test_async_reset();
        put(0, 0); put(5, 1);
        cursor_load = 1; cursor_idx = 4'd8;
        tick();
        #2 reset = 0;
        #1;
        n_checks++;
        if ({board, cursor, move_count, legal_move, illegal, winner_found, winner, full} !== {18'd0, 4'd4, 4'd0, 6'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got board=%h cursor=%0d count=%0d flags=%b, want 0/4/0/000000", board, cursor, move_count, {legal_move, illegal, winner_found, winner, full});
        end
        reset = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_cursor_move();
        test_place();
        test_win();
        test_draw();
        test_load_invalid();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
